// File: rtl/tile_pair_ctrl_if.sv
// Handshake bundle between mouse/geometry decode, the pair controller and the per-tile draw muxes.
interface tile_pair_ctrl_if #(
  parameter int N_TILES = 6,
  parameter int ID_W    = 3
);
  localparam int PF_W = $clog2(N_TILES/2 + 1);

  logic                     mouse_left;
  logic [N_TILES-1:0]       tile_hit;
  logic [N_TILES*ID_W-1:0]  pair_id;
  logic                     new_game;
  logic [N_TILES-1:0]       tile_face;
  logic [N_TILES-1:0]       tile_locked;
  logic                     match_pulse;
  logic                     mismatch_pulse;
  logic [PF_W-1:0]          pairs_found;
  logic [7:0]               moves;
  logic                     busy;
  logic                     game_done;

  modport master (
    output mouse_left, tile_hit, pair_id, new_game,
    input  tile_face, tile_locked, match_pulse, mismatch_pulse,
           pairs_found, moves, busy, game_done
  );

  modport slave (
    input  mouse_left, tile_hit, pair_id, new_game,
    output tile_face, tile_locked, match_pulse, mismatch_pulse,
           pairs_found, moves, busy, game_done
  );
endinterface

// File: rtl/tile_pair_ctrl.sv
// Memory-game controller: turns click edges on tile hit-boxes into face-up/locked tile state,
// compares the two picked tiles' pair IDs and re-hides a wrong pair after a hold time.
module tile_pair_ctrl #(
  parameter int N_TILES     = 6,
  parameter int ID_W        = 3,
  parameter int SHOW_CYCLES = 65_000_000
) (
  input  logic             clk,
  input  logic             rst,
  tile_pair_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(N_TILES);
  localparam int PF_W  = $clog2(N_TILES/2 + 1);
  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [PF_W-1:0]  LAST_PAIR = PF_W'(N_TILES/2 - 1);

  typedef enum logic [2:0] {PICK1, PICK2, CMP, SHOW, DONE} state_t;

  state_t             state;
  logic               mouse_left_q;
  logic [N_TILES-1:0] face;
  logic [N_TILES-1:0] locked;
  logic [IDX_W-1:0]   first;
  logic [IDX_W-1:0]   second;
  logic [CNT_W-1:0]   cnt;
  logic [PF_W-1:0]    pairs;
  logic [7:0]         moves;
  logic               match_p;
  logic               mismatch_p;
  logic               busy;
  logic               done;

  logic               click;
  logic               valid_pick;
  logic [IDX_W-1:0]   hit_idx;
  logic               ids_equal;

  function automatic logic [ID_W-1:0] id_of(input logic [N_TILES*ID_W-1:0] ids,
                                            input logic [IDX_W-1:0] idx);
    return ids[int'(idx)*ID_W +: ID_W];
  endfunction

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < N_TILES; i++)
      if (bus.tile_hit[i]) hit_idx = IDX_W'(i);
  end

  // A pick needs a fresh press, exactly one tile under the cursor, and that tile still hidden.
  assign click      = bus.mouse_left & ~mouse_left_q;
  assign valid_pick = click && $onehot(bus.tile_hit) &&
                      ((bus.tile_hit & (face | locked)) == '0);
  assign ids_equal  = (id_of(bus.pair_id, first) == id_of(bus.pair_id, second));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PICK1;
      mouse_left_q <= 1'b0;
      face         <= '0;
      locked       <= '0;
      cnt          <= '0;
      pairs        <= '0;
      moves        <= '0;
      match_p      <= 1'b0;
      mismatch_p   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      mouse_left_q <= bus.mouse_left;
      match_p      <= 1'b0;
      mismatch_p   <= 1'b0;
      if (bus.new_game) begin
        state  <= PICK1;
        face   <= '0;
        locked <= '0;
        cnt    <= '0;
        pairs  <= '0;
        moves  <= '0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (state)
          PICK1: if (valid_pick) begin
            face[hit_idx] <= 1'b1;
            state         <= PICK2;
          end
          PICK2: if (valid_pick) begin
            face[hit_idx] <= 1'b1;
            busy          <= 1'b1;
            state         <= CMP;
          end
          CMP: begin
            if (moves != 8'hFF) moves <= moves + 8'd1;
            if (ids_equal) begin
              locked[first]  <= 1'b1;
              locked[second] <= 1'b1;
              match_p        <= 1'b1;
              pairs          <= pairs + 1'b1;
              busy           <= 1'b0;
              if (pairs == LAST_PAIR) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= PICK1;
              end
            end else begin
              mismatch_p <= 1'b1;
              cnt        <= CNT_LOAD;
              state      <= SHOW;
            end
          end
          // The pair stays visible for SHOW_CYCLES edges counted from the compare.
          SHOW: begin
            if (cnt == '0) begin
              face[first]  <= 1'b0;
              face[second] <= 1'b0;
              busy         <= 1'b0;
              state        <= PICK1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DONE:    face  <= '1;
          default: state <= PICK1;
        endcase
      end
    end
  end

  // Picked tile indices are plain data; they are only read after being written in this game.
  always_ff @(posedge clk) begin
    if (!bus.new_game && valid_pick) begin
      if (state == PICK1) first  <= hit_idx;
      if (state == PICK2) second <= hit_idx;
    end
  end

  assign bus.tile_face      = face;
  assign bus.tile_locked    = locked;
  assign bus.match_pulse    = match_p;
  assign bus.mismatch_pulse = mismatch_p;
  assign bus.pairs_found    = pairs;
  assign bus.moves          = moves;
  assign bus.busy           = busy;
  assign bus.game_done      = done;
endmodule

// File: tb/tb_tile_pair_ctrl.sv
// Directed bench for tile_pair_ctrl: 4 tiles, IDs t0=0 t1=1 t2=0 t3=1, 4-cycle mismatch hold.
module tb_tile_pair_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  tile_pair_ctrl_if #(.N_TILES(4), .ID_W(2)) bus ();

  tile_pair_ctrl #(.N_TILES(4), .ID_W(2), .SHOW_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int t);
    bus.tile_hit   = 4'(4'b0001 << t);
    bus.mouse_left = 1'b1;
    tick();
  endtask

  task automatic release_btn();
    bus.mouse_left = 1'b0;
    bus.tile_hit   = 4'b0000;
    tick();
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    vectors++; if (bus.tile_face !== 4'b0000) begin miscompares++; $display("FAIL reset_face got %b want 0000", bus.tile_face); end
    vectors++; if (bus.tile_locked !== 4'b0000) begin miscompares++; $display("FAIL reset_locked got %b want 0000", bus.tile_locked); end
    vectors++; if ({bus.match_pulse, bus.mismatch_pulse, bus.busy, bus.game_done} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {bus.match_pulse, bus.mismatch_pulse, bus.busy, bus.game_done}); end
    vectors++; if (bus.pairs_found !== 2'd0 || bus.moves !== 8'd0) begin miscompares++; $display("FAIL reset_counts got pairs %0d moves %0d want 0 0", bus.pairs_found, bus.moves); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_match();
    press(0);
    vectors++; if (bus.tile_face !== 4'b0001) begin miscompares++; $display("FAIL match_pick1_face got %b want 0001", bus.tile_face); end
    release_btn();
    press(2);
    vectors++; if (bus.tile_face !== 4'b0101 || bus.busy !== 1'b1 || bus.match_pulse !== 1'b0) begin miscompares++; $display("FAIL match_pick2 got face %b busy %b match %b want 0101 1 0", bus.tile_face, bus.busy, bus.match_pulse); end
    release_btn();
    vectors++; if (bus.match_pulse !== 1'b1 || bus.mismatch_pulse !== 1'b0) begin miscompares++; $display("FAIL match_pulse got %b/%b want 1/0", bus.match_pulse, bus.mismatch_pulse); end
    vectors++; if (bus.tile_locked !== 4'b0101 || bus.tile_face !== 4'b0101) begin miscompares++; $display("FAIL match_lock got locked %b face %b want 0101 0101", bus.tile_locked, bus.tile_face); end
    vectors++; if (bus.pairs_found !== 2'd1 || bus.moves !== 8'd1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL match_counts got pairs %0d moves %0d busy %b want 1 1 0", bus.pairs_found, bus.moves, bus.busy); end
    tick();
    vectors++; if (bus.match_pulse !== 1'b0) begin miscompares++; $display("FAIL match_pulse_width got %b want 0", bus.match_pulse); end
  endtask

  task automatic test_mismatch();
    int busy_cycles;
    pulse_new_game();
    press(0);
    release_btn();
    press(1);
    busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
    release_btn();
    vectors++; if (bus.mismatch_pulse !== 1'b1 || bus.match_pulse !== 1'b0) begin miscompares++; $display("FAIL mismatch_pulse got %b/%b want 1/0", bus.mismatch_pulse, bus.match_pulse); end
    vectors++; if (bus.tile_face !== 4'b0011 || bus.moves !== 8'd1 || bus.tile_locked !== 4'b0000) begin miscompares++; $display("FAIL mismatch_state got face %b moves %0d locked %b want 0011 1 0000", bus.tile_face, bus.moves, bus.tile_locked); end
    if (bus.busy === 1'b1) busy_cycles++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.busy === 1'b1) busy_cycles++;
    end
    vectors++; if (bus.tile_face !== 4'b0011 || bus.mismatch_pulse !== 1'b0) begin miscompares++; $display("FAIL mismatch_hold got face %b pulse %b want 0011 0", bus.tile_face, bus.mismatch_pulse); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.busy === 1'b1) busy_cycles++;
    end
    vectors++; if (busy_cycles !== 5) begin miscompares++; $display("FAIL mismatch_busy_cycles got %0d want 5", busy_cycles); end
    vectors++; if (bus.tile_face !== 4'b0000) begin miscompares++; $display("FAIL mismatch_hide got %b want 0000", bus.tile_face); end
  endtask

  task automatic test_held_button();
    pulse_new_game();
    press(0);
    bus.tile_hit = 4'b0010;
    tick();
    tick();
    vectors++; if (bus.tile_face !== 4'b0001) begin miscompares++; $display("FAIL held_drag got %b want 0001", bus.tile_face); end
    release_btn();
    press(0);
    release_btn();
    vectors++; if (bus.tile_face !== 4'b0001 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL reclick_up got face %b busy %b want 0001 0", bus.tile_face, bus.busy); end
  endtask

  task automatic test_ignored_clicks();
    pulse_new_game();
    press(0);
    release_btn();
    press(1);
    release_btn();
    press(3);
    vectors++; if (bus.tile_face !== 4'b0011) begin miscompares++; $display("FAIL show_click got %b want 0011", bus.tile_face); end
    release_btn();
    for (int c = 0; c < 20 && bus.busy === 1'b1; c++) tick();
    vectors++; if (bus.busy !== 1'b0 || bus.tile_face !== 4'b0000) begin miscompares++; $display("FAIL show_end got busy %b face %b want 0 0000", bus.busy, bus.tile_face); end
    bus.tile_hit   = 4'b0011;
    bus.mouse_left = 1'b1;
    tick();
    vectors++; if (bus.tile_face !== 4'b0000) begin miscompares++; $display("FAIL multi_hit got %b want 0000", bus.tile_face); end
    release_btn();
    press(0);
    release_btn();
    press(2);
    release_btn();
    press(2);
    release_btn();
    vectors++; if (bus.tile_face !== 4'b0101 || bus.tile_locked !== 4'b0101 || bus.moves !== 8'd2) begin miscompares++; $display("FAIL locked_click got face %b locked %b moves %0d want 0101 0101 2", bus.tile_face, bus.tile_locked, bus.moves); end
    press(3);
    vectors++; if (bus.tile_face !== 4'b1101) begin miscompares++; $display("FAIL after_locked_pick got %b want 1101", bus.tile_face); end
    release_btn();
  endtask

  task automatic test_game_done();
    pulse_new_game();
    press(0); release_btn(); press(2); release_btn();
    vectors++; if (bus.game_done !== 1'b0) begin miscompares++; $display("FAIL done_early got %b want 0", bus.game_done); end
    press(1); release_btn(); press(3); release_btn();
    vectors++; if (bus.pairs_found !== 2'd2 || bus.game_done !== 1'b1 || bus.match_pulse !== 1'b1) begin miscompares++; $display("FAIL done_set got pairs %0d done %b match %b want 2 1 1", bus.pairs_found, bus.game_done, bus.match_pulse); end
    vectors++; if (bus.tile_locked !== 4'b1111 || bus.tile_face !== 4'b1111 || bus.moves !== 8'd2) begin miscompares++; $display("FAIL done_tiles got locked %b face %b moves %0d want 1111 1111 2", bus.tile_locked, bus.tile_face, bus.moves); end
    tick();
    vectors++; if (bus.game_done !== 1'b1 || bus.tile_face !== 4'b1111) begin miscompares++; $display("FAIL done_hold got done %b face %b want 1 1111", bus.game_done, bus.tile_face); end
    bus.tile_hit   = 4'b0010;
    bus.mouse_left = 1'b1;
    pulse_new_game();
    vectors++; if (bus.tile_face !== 4'b0000 || bus.tile_locked !== 4'b0000 || bus.game_done !== 1'b0) begin miscompares++; $display("FAIL newgame_tiles got face %b locked %b done %b want 0000 0000 0", bus.tile_face, bus.tile_locked, bus.game_done); end
    vectors++; if (bus.pairs_found !== 2'd0 || bus.moves !== 8'd0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL newgame_counts got pairs %0d moves %0d busy %b want 0 0 0", bus.pairs_found, bus.moves, bus.busy); end
    release_btn();
    press(1);
    vectors++; if (bus.tile_face !== 4'b0010) begin miscompares++; $display("FAIL newgame_pick1 got %b want 0010", bus.tile_face); end
    release_btn();
  endtask

  task automatic test_reset_and_saturation();
    int stuck;
    pulse_new_game();
    press(0); release_btn(); press(1); release_btn();
    tick();
    vectors++; if (bus.tile_face !== 4'b0011 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL pre_rst got face %b busy %b want 0011 1", bus.tile_face, bus.busy); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.tile_face !== 4'b0000 || bus.busy !== 1'b0 || bus.moves !== 8'd0) begin miscompares++; $display("FAIL async_rst got face %b busy %b moves %0d want 0000 0 0", bus.tile_face, bus.busy, bus.moves); end
    tick();
    rst = 1'b0;
    tick();
    vectors++; if (bus.match_pulse !== 1'b0 || bus.mismatch_pulse !== 1'b0 || bus.tile_face !== 4'b0000) begin miscompares++; $display("FAIL post_rst got match %b mismatch %b face %b want 0 0 0000", bus.match_pulse, bus.mismatch_pulse, bus.tile_face); end
    stuck = 0;
    for (int a = 1; a <= 300; a++) begin
      press(0); release_btn(); press(1); release_btn();
      for (int c = 0; c < 20 && bus.busy === 1'b1; c++) tick();
      if (bus.busy === 1'b1) stuck++;
      if (a == 254) begin
        vectors++; if (bus.moves !== 8'd254) begin miscompares++; $display("FAIL moves_254 got %0d want 254", bus.moves); end
      end
    end
    vectors++; if (stuck !== 0) begin miscompares++; $display("FAIL show_timeout got %0d stuck attempts want 0", stuck); end
    vectors++; if (bus.moves !== 8'd255) begin miscompares++; $display("FAIL moves_sat got %0d want 255", bus.moves); end
  endtask

  initial begin
    bus.mouse_left = 1'b0;
    bus.tile_hit   = 4'b0000;
    bus.pair_id    = {2'd1, 2'd0, 2'd1, 2'd0};
    bus.new_game   = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_held_button();
    test_ignored_clicks();
    test_game_done();
    test_reset_and_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
